// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_pkg
// Purpose  : Shared constants and types for the multi-port register file.
//            Holds the default geometry and the bulk-clear FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int NUM_RD_DEF = 2;

   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_RUN  = 2'd1,
      CLR_DONE = 2'd2
   } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_clr_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_clr_seq
// Purpose  : Bulk-clear sequencer. Walks every clearable register index, one
//            per cycle, then pulses done for a single cycle.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            clr_req        - start request, sampled only while idle
//            clr_busy       - high while the sweep is in progress
//            clr_done       - one-cycle completion pulse
//            clr_we/clr_idx - zero-write strobe and target index for storage
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_clr_seq
   import regfile_mp_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   // A hardwired register 0 never needs clearing, so the sweep skips it.
   localparam logic [ADDR_W-1:0] C_FIRST_IDX = ADDR_W'((ZERO_REG != 0) ? 1 : 0);
   localparam logic [ADDR_W-1:0] C_LAST_IDX  = ADDR_W'(DEPTH - 1);

   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_RUN;
               cnt_d   = C_FIRST_IDX;
            end
         end
         CLR_RUN: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == C_LAST_IDX) begin
               state_d = CLR_DONE;
            end
         end
         CLR_DONE: begin
            state_d = CLR_IDLE;
         end
         default: begin
            state_d = CLR_IDLE;
         end
      endcase
      // Status flags are registered copies of the next state so they line
      // up exactly with the state they describe.
      busy_d = (state_d == CLR_RUN);
      done_d = (state_d == CLR_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign clr_busy = busy_q;
   assign clr_done = done_q;
   assign clr_we   = busy_q;
   assign clr_idx  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised integer register file with NUM_RD combinational read
//            ports, one write port with ready handshake, and a sequenced
//            bulk-clear engine. Optional build macro REGFILE_MP_BYPASS_EN adds
//            same-cycle write-to-read forwarding.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            rd_addr / rd_data   - packed read ports, port p at slice p
//            wr_en/wr_addr/wr_data - write request, commits when wr_ready
//            wr_ready            - low while a clear sweep is running
//            clr_req/clr_busy/clr_done - bulk-clear control and status
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = NUM_RD_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_ready,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done
);

   // One extra bit so non-power-of-two depths compare correctly.
   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              w_wr_ok;

   regfile_mp_clr_seq #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   assign wr_ready = !clr_busy;

   // A write is legal only when accepted, in range and not aimed at a
   // hardwired zero register; illegal writes vanish silently.
   assign w_wr_ok = wr_en && wr_ready
                    && ({1'b0, wr_addr} < C_DEPTH)
                    && !((ZERO_REG != 0) && (wr_addr == '0));

   // Normal write and clear write never coincide because wr_ready is low
   // for the whole sweep.
   always_comb begin
      mem_d = mem_q;
      if (w_wr_ok) begin
         mem_d[wr_addr] = wr_data;
      end
      if (clr_we) begin
         mem_d[clr_idx] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic [DATA_W-1:0] w_data;

         assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

         always_comb begin
            w_data = '0;
            if (({1'b0, w_addr} < C_DEPTH)
                && !((ZERO_REG != 0) && (w_addr == '0))) begin
               w_data = mem_q[w_addr];
`ifdef REGFILE_MP_BYPASS_EN
               if (w_wr_ok && (wr_addr == w_addr)) begin
                  w_data = wr_data;
               end
`endif
            end
         end

         assign rd_data[p*DATA_W +: DATA_W] = w_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file, successor to the fixed 32x32 two-read-port register file in the single-cycle RISC-V datapath. It adds configurable width, depth and read-port count, an asynchronous active-low reset, and a sequenced bulk-clear engine with a write-ready handshake. It sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (≥2)
- ADDR_W, $clog2(DEPTH), address width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is ordinary storage
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed read data, same packing
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- wr_ready  output  1  write port accepting; a write commits only when wr_en && wr_ready
- clr_req  input  1  start bulk clear (level sampled in IDLE)
- clr_busy  output  1  clear sequence in progress
- clr_done  output  1  one-cycle pulse on clear completion

## Operation
- Reads combinational; each port independent; addr ≥ DEPTH returns 0; addr 0 returns 0 when ZERO_REG=1.
- Write commits at rising edge when wr_en && wr_ready; dropped if wr_addr ≥ DEPTH or (ZERO_REG=1 and wr_addr==0). No error flag.
- wr_ready = !clr_busy. Writes presented while busy are discarded, not queued.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 → CLEAR; counter loaded with first clearable index (1 if ZERO_REG else 0).
  - CLEAR: zero register[counter] each cycle, counter++; when counter==DEPTH-1 is cleared → DONE. clr_req ignored.
  - DONE: clr_done=1 for this cycle only → IDLE. clr_req sampled again only in IDLE (next cycle).
- Reads during CLEAR return current storage: already-cleared entries 0, others old values.
- clr_req and committing write in the same IDLE cycle: write commits, clear starts next cycle and later zeroes that entry.
- Reset (rst_n low, any time, including mid-clear): all storage 0, FSM IDLE, counter 0; immediate, clock-independent.

## Timing
- Reset values: rd_data = 0 on all ports, wr_ready=1, clr_busy=0, clr_done=0.
- Read latency 0 cycles (combinational from rd_addr and storage).
- Write visible to reads the cycle after commit edge (bypass disabled).
- Clear duration: clr_busy high for N = DEPTH-ZERO_REG cycles, starting cycle after clr_req sampled; clr_done high in cycle N+1; wr_ready returns high in the clr_done cycle.
- clr_busy is registered (state==CLEAR); clr_done registered (state==DONE).

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding; if wr_en && wr_ready && wr_addr==rd_addr[p] and the write is legal (in range, not hardwired zero), rd_data[p] = wr_data in the same cycle. Combinational path wr_data→rd_data exists.
- Undefined: no forwarding; same-cycle read returns the old stored value.

## Structure
- Package regfile_mp_pkg: default DATA_W/DEPTH/NUM_RD constants, clear FSM state enum (clr_state_t: CLR_IDLE, CLR_RUN, CLR_DONE).
- Sub-module regfile_mp_clr_seq: FSM plus index counter; outputs clr_busy, clr_done, clr_we, clr_idx. The top-level storage array muxes the clear write over the normal write (mutually exclusive by wr_ready).
- Storage is a generate-sized array, not discrete named registers.

## Test plan
- Reset then read all addresses on both ports → 0; write x5=0xDEADBEEF, read x5 next cycle → 0xDEADBEEF; write x0=0x1234 with ZERO_REG=1 → x0 reads 0.
- Fill x1..x31 with index*0x11, clr_req one cycle → clr_busy high exactly 31 cycles, clr_done pulse in cycle 32, all reads 0, wr_ready low throughout busy.
- During CLEAR, wr_en to x10=0xAAAA → dropped; after done x10 reads 0; clr_req held high through CLEAR → exactly one sequence, then a second starts from IDLE.
- Same cycle clr_req=1 and write x3=0x55 → x3 reads 0x55 for first cleared cycles, 0 after clear.
- Assert rst_n low mid-clear (counter=12) → outputs immediately at reset values, x20 (not yet cleared, was 0x20) reads 0, FSM restarts IDLE.
- With REGFILE_MP_BYPASS_EN: write x7=0xCAFE while rd_addr port1=7 → rd_data port1=0xCAFE same cycle; without the macro → old value of x7; NUM_RD=4, DEPTH=24: read addr 30 → 0.
